alu_result_mux_reg: RTL and testbench
=====================================

ALU_RESULT_MUX_REG -- requirements
Module: alu_result_mux_reg

Interface
REQ-001 Parameter WIDTH, default 16, bit width of every operand channel and of the result.
REQ-002 Parameter NUM_OPS, default 12, number of one-hot operation channels (legal range 2..32).
REQ-003 Parameter CNT_W, default 8, width of the illegal-select counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 op_data  input  NUM_OPS*WIDTH  concatenated channel results; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 sel  input  NUM_OPS  one-hot operation select; bit NUM_OPS-1 is the CLEAR operation.
REQ-008 in_valid  input  1  sel/op_data valid this cycle.
REQ-009 in_ready  output  1  block accepts a transfer this cycle.
REQ-010 res  output  WIDTH  registered selected result.
REQ-011 res_valid  output  1  res holds an unconsumed result.
REQ-012 out_ready  input  1  downstream accepts res this cycle.
REQ-013 res_err  output  1  res was produced from an illegal (non-one-hot) sel.
REQ-014 err_sticky  output  1  set on any accepted illegal sel; held until CLEAR or reset.
REQ-015 err_count  output  CNT_W  count of accepted illegal sels, saturating.

Function
REQ-016 Transfer in occurs when in_valid && in_ready; transfer out occurs when res_valid && out_ready.
REQ-017 in_ready = !res_valid || out_ready (combinational; single pipeline register, full throughput).
REQ-018 Latency: one cycle from accepted transfer in to res_valid high with the corresponding res.
REQ-019 Legal sel (exactly one bit set, bits 0..NUM_OPS-2): res <= channel of the set bit, res_err <= 0.
REQ-020 sel == CLEAR only: res <= 0, res_err <= 0, err_sticky <= 0, err_count <= 0 in the same edge.
REQ-021 Illegal sel (zero bits or two or more bits set, CLEAR included in a multi-bit pattern): res <= 0, res_err <= 1, err_sticky <= 1, err_count increments; no clearing occurs.
REQ-022 err_count saturates at 2^CNT_W-1; further illegal sels leave it unchanged and still set res_err.
REQ-023 While res_valid && !out_ready: res, res_err, res_valid held stable; in_ready low; sel/op_data ignored.
REQ-024 Transfer out without transfer in: res_valid <= 0; res and res_err retain their values.
REQ-025 Simultaneous transfer out and transfer in: res_valid stays 1, new result loaded, no bubble.
REQ-026 in_valid low: no state other than res_valid (per REQ-024) changes; op_data/sel values are don't-care.
REQ-027 Result captured only on transfer in; changes to op_data after acceptance do not affect res.

Reset
REQ-028 rst high at a clock edge: res = 0, res_valid = 0, res_err = 0, err_sticky = 0, err_count = 0.
REQ-029 rst overrides any simultaneous transfer in or CLEAR; a pending unconsumed result is discarded.
REQ-030 in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-031 Shared package alu_pkg holds the one-hot op constants (OP_AND, OP_OR, OP_NOT, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ADD, OP_SUB, OP_SHRIGHT, OP_SHLEFT, OP_CLEAR = bits 0..11 as in the ALU select encoding) and default WIDTH/NUM_OPS.
REQ-032 Sub-module onehot_check (parameter N) outputs is_onehot and index; instantiated once for sel.
REQ-033 Selection implemented as AND-OR over channels gated by legality, no priority chain.

Verification
REQ-034 Defaults, sel=0x001, channel0=0x1234, out_ready=1 -> next cycle res=0x1234, res_valid=1, res_err=0.
REQ-035 sel=0x003 -> res=0x0000, res_err=1, err_sticky=1, err_count=1; then sel=0x800 -> res=0, err_sticky=0, err_count=0.
REQ-036 out_ready=0 with res_valid=1 for 3 cycles while sel/op_data change -> res stable, in_ready=0; out_ready=1 -> next beat loaded same edge.
REQ-037 Back-to-back legal sels 0x080, 0x100, 0x400 with out_ready=1 -> three results on consecutive cycles, no bubble.
REQ-038 CNT_W=2, five illegal sels (0x000) -> err_count sticks at 3, res_err=1 each beat.
REQ-039 rst asserted while res_valid=1, out_ready=0 -> next cycle res_valid=0, res=0, err_count=0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU select encoding and default datapath sizing.
// Select vectors are one-hot; bit positions match the ALU op channel order.
package alu_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NUM_OPS = 12;

  typedef logic [DEF_NUM_OPS-1:0] op_sel_t;

  localparam op_sel_t OP_AND     = 12'h001;
  localparam op_sel_t OP_OR      = 12'h002;
  localparam op_sel_t OP_NOT     = 12'h004;
  localparam op_sel_t OP_XOR     = 12'h008;
  localparam op_sel_t OP_NAND    = 12'h010;
  localparam op_sel_t OP_NOR     = 12'h020;
  localparam op_sel_t OP_XNOR    = 12'h040;
  localparam op_sel_t OP_ADD     = 12'h080;
  localparam op_sel_t OP_SUB     = 12'h100;
  localparam op_sel_t OP_SHRIGHT = 12'h200;
  localparam op_sel_t OP_SHLEFT  = 12'h400;
  localparam op_sel_t OP_CLEAR   = 12'h800;

endpackage

// File: rtl/onehot_check.sv
// Flags whether a vector has exactly one bit set and reports that bit's index.
// The index is an OR of the set bit positions, so it is only meaningful when is_onehot is high.
module onehot_check #(
  parameter int N = 12
) (
  input  logic [N-1:0]         in_vec,
  output logic                 is_onehot,
  output logic [$clog2(N)-1:0] index
);

  localparam int IDX_W = $clog2(N);

  logic [N-1:0] low_cleared;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign low_cleared = in_vec & (in_vec - N'(1));
  assign is_onehot   = (in_vec != '0) && (low_cleared == '0);

  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      index = index | (IDX_W'(i) & {IDX_W{in_vec[i]}});
    end
  end

endmodule

// File: rtl/alu_result_mux_reg.sv
// Registers the result of the one-hot selected ALU channel behind a valid/ready handshake,
// tracking illegal selects with a sticky flag and a saturating counter; the top select bit is CLEAR.
module alu_result_mux_reg
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_OPS = DEF_NUM_OPS,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_OPS*WIDTH-1:0] op_data,
  input  logic [NUM_OPS-1:0]       sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         res,
  output logic                     res_valid,
  input  logic                     out_ready,
  output logic                     res_err,
  output logic                     err_sticky,
  output logic [CNT_W-1:0]         err_count
);

  localparam int                IDX_W     = $clog2(NUM_OPS);
  localparam logic [IDX_W-1:0] CLEAR_IDX = IDX_W'(NUM_OPS - 1);

  logic             sel_onehot;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_is_clear;
  logic             sel_legal;
  logic             xfer_in;
  logic             xfer_out;
  logic [WIDTH-1:0] mux_res;

  logic [WIDTH-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             res_err_q, res_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  onehot_check #(.N(NUM_OPS)) u_sel_check (
    .in_vec   (sel),
    .is_onehot(sel_onehot),
    .index    (sel_idx)
  );

  assign sel_is_clear = sel_onehot && (sel_idx == CLEAR_IDX);
  assign sel_legal    = sel_onehot && !sel_is_clear;

  assign in_ready = !res_valid_q || out_ready;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = res_valid_q && out_ready;

  // Flat AND-OR: every channel is gated by its own select bit and overall legality,
  // which also keeps the CLEAR channel's data out of the result.
  always_comb begin
    mux_res = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      mux_res = mux_res | (op_data[i*WIDTH +: WIDTH] & {WIDTH{sel[i] & sel_legal}});
    end
  end

  always_comb begin
    res_d        = res_q;
    res_valid_d  = res_valid_q;
    res_err_d    = res_err_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    if (xfer_in) begin
      res_valid_d = 1'b1;
      if (sel_is_clear) begin
        res_d        = '0;
        res_err_d    = 1'b0;
        err_sticky_d = 1'b0;
        err_count_d  = '0;
      end else if (sel_legal) begin
        res_d     = mux_res;
        res_err_d = 1'b0;
      end else begin
        res_d        = '0;
        res_err_d    = 1'b1;
        err_sticky_d = 1'b1;
        if (err_count_q != '1) begin
          err_count_d = err_count_q + CNT_W'(1);
        end
      end
    end else if (xfer_out) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q        <= '0;
      res_valid_q  <= 1'b0;
      res_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      res_q        <= res_d;
      res_valid_q  <= res_valid_d;
      res_err_q    <= res_err_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign res        = res_q;
  assign res_valid  = res_valid_q;
  assign res_err    = res_err_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_alu_result_mux_reg.sv
// Self-checking bench: directed scenarios with fixed expectations, plus a randomized run
// compared against a behavioural model of the select/handshake rules.
module tb_alu_result_mux_reg;
  import alu_pkg::*;

  localparam int W = 16;
  localparam int N = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] op_data, op_data2;
  logic [N-1:0]   sel, sel2;
  logic           in_valid, in_valid2, out_ready, out_ready2;
  logic           in_ready, in_ready2;
  logic [W-1:0]   res, res2;
  logic           res_valid, res_valid2, res_err, res_err2, err_sticky, err_sticky2;
  logic [7:0]     err_count;
  logic [1:0]     err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_mux_reg dut (
    .clk(clk), .rst(rst), .op_data(op_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .res(res), .res_valid(res_valid), .out_ready(out_ready),
    .res_err(res_err), .err_sticky(err_sticky), .err_count(err_count)
  );

  alu_result_mux_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .op_data(op_data2), .sel(sel2), .in_valid(in_valid2),
    .in_ready(in_ready2), .res(res2), .res_valid(res_valid2), .out_ready(out_ready2),
    .res_err(res_err2), .err_sticky(err_sticky2), .err_count(err_count2)
  );

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = 16'($urandom);
    return d;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; sel = OP_AND; op_data = rand_data(); out_ready = 1'b0;
    in_valid2 = 1'b1; sel2 = 12'h000; op_data2 = rand_data(); out_ready2 = 1'b0;
    cyc(); cyc();
    rst = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    #1;
    checks++;
    if (res !== 16'h0 || res_valid !== 1'b0 || res_err !== 1'b0 || err_sticky !== 1'b0 || err_count !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: res=%h v=%b e=%b st=%b cnt=%0d, required all zero", res, res_valid, res_err, err_sticky, err_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    checks++;
    if (res_valid2 !== 1'b0 || err_count2 !== 2'd0 || in_ready2 !== 1'b1) begin
      errors++; $display("FAIL reset_dut2: v=%b cnt=%0d rdy=%b required 0 0 1", res_valid2, err_count2, in_ready2);
    end
  endtask

  task automatic test_basic();
    op_data = rand_data(); op_data[15:0] = 16'h1234;
    sel = OP_AND; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; op_data = rand_data();
    checks++;
    if (res !== 16'h1234 || res_valid !== 1'b1 || res_err !== 1'b0) begin
      errors++; $display("FAIL basic_select: res=%h v=%b e=%b required 1234 1 0", res, res_valid, res_err);
    end
    cyc();
    checks++;
    if (res_valid !== 1'b0 || res !== 16'h1234) begin
      errors++; $display("FAIL drain_hold: v=%b res=%h required 0 1234", res_valid, res);
    end
  endtask

  task automatic test_illegal_clear();
    op_data = rand_data(); sel = 12'h003; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    checks++;
    if (res !== 16'h0 || res_err !== 1'b1 || err_sticky !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL illegal_sel: res=%h e=%b st=%b cnt=%0d required 0 1 1 1", res, res_err, err_sticky, err_count);
    end
    op_data = rand_data(); sel = OP_CLEAR;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (res !== 16'h0 || res_err !== 1'b0 || err_sticky !== 1'b0 || err_count !== 8'd0 || res_valid !== 1'b1) begin
      errors++; $display("FAIL clear_sel: res=%h e=%b st=%b cnt=%0d v=%b required 0 0 0 0 1", res, res_err, err_sticky, err_count, res_valid);
    end
    cyc();
  endtask

  task automatic test_stall();
    op_data = rand_data(); op_data[2*W +: W] = 16'hABCD;
    sel = OP_NOT; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = 12'($urandom); op_data = rand_data();
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_in_ready[%0d]: got %b required 0", k, in_ready);
      end
      cyc();
      checks++;
      if (res !== 16'hABCD || res_valid !== 1'b1 || res_err !== 1'b0 || err_count !== 8'd0) begin
        errors++; $display("FAIL stall_hold[%0d]: res=%h v=%b e=%b cnt=%0d required abcd 1 0 0", k, res, res_valid, res_err, err_count);
      end
    end
    out_ready = 1'b1; sel = OP_NAND; op_data = rand_data(); op_data[4*W +: W] = 16'h5A5A;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready: got %b required 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    checks++;
    if (res !== 16'h5A5A || res_valid !== 1'b1) begin
      errors++; $display("FAIL stall_release_load: res=%h v=%b required 5a5a 1", res, res_valid);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ops [3];
    int           chans [3];
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_SHLEFT;
    chans[0] = 7; chans[1] = 8; chans[2] = 10;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] want;
      op_data = rand_data(); sel = ops[k];
      want = op_data[chans[k]*W +: W];
      cyc();
      checks++;
      if (res !== want || res_valid !== 1'b1 || res_err !== 1'b0) begin
        errors++; $display("FAIL back_to_back[%0d]: res=%h v=%b e=%b required %h 1 0", k, res, res_valid, res_err, want);
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_saturate();
    in_valid2 = 1'b1; out_ready2 = 1'b1; sel2 = 12'h000; op_data2 = rand_data();
    for (int k = 1; k <= 5; k++) begin
      int want;
      want = (k > 3) ? 3 : k;
      cyc();
      checks++;
      if (int'(err_count2) !== want || res_err2 !== 1'b1 || res2 !== 16'h0 || err_sticky2 !== 1'b1) begin
        errors++; $display("FAIL saturate[%0d]: cnt=%0d e=%b res=%h st=%b required %0d 1 0 1", k, err_count2, res_err2, res2, err_sticky2, want);
      end
    end
    in_valid2 = 1'b0;
  endtask

  task automatic test_reset_pending();
    op_data = rand_data(); sel = 12'h003; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    checks++;
    if (res_valid !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL pending_before_rst: v=%b cnt=%0d required 1 1", res_valid, err_count);
    end
    rst = 1'b1; in_valid = 1'b1; sel = OP_OR;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res !== 16'h0 || err_count !== 8'd0 || err_sticky !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_pending: v=%b res=%h cnt=%0d st=%b rdy=%b required 0 0 0 0 1", res_valid, res, err_count, err_sticky, in_ready);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] m_res;
    logic         m_valid, m_err, m_sticky;
    int           m_cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    m_res = '0; m_valid = 1'b0; m_err = 1'b0; m_sticky = 1'b0; m_cnt = 0;
    for (int t = 0; t < 400; t++) begin
      int  kind;
      logic exp_rdy;
      kind = $urandom_range(0, 3);
      case (kind)
        0:       sel = 12'(1) << $urandom_range(0, N - 2);
        1:       sel = OP_CLEAR;
        2:       sel = 12'($urandom);
        default: sel = (12'(1) << $urandom_range(0, N - 1)) | (12'(1) << $urandom_range(0, N - 1));
      endcase
      op_data   = rand_data();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      #1;
      exp_rdy = !m_valid || out_ready;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b required %b", t, in_ready, exp_rdy);
      end
      if (rst) begin
        m_res = '0; m_valid = 1'b0; m_err = 1'b0; m_sticky = 1'b0; m_cnt = 0;
      end else if (in_valid && exp_rdy) begin
        m_valid = 1'b1;
        if ($countones(sel) == 1 && sel[N-1]) begin
          m_res = '0; m_err = 1'b0; m_sticky = 1'b0; m_cnt = 0;
        end else if ($countones(sel) == 1) begin
          for (int c = 0; c < N; c++) if (sel[c]) m_res = op_data[c*W +: W];
          m_err = 1'b0;
        end else begin
          m_res = '0; m_err = 1'b1; m_sticky = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      cyc();
      checks++;
      if (res !== m_res || res_valid !== m_valid || res_err !== m_err || err_sticky !== m_sticky || int'(err_count) !== m_cnt) begin
        errors++;
        $display("FAIL rand_state[%0d]: res=%h v=%b e=%b st=%b cnt=%0d required %h %b %b %b %0d",
                 t, res, res_valid, res_err, err_sticky, err_count, m_res, m_valid, m_err, m_sticky, m_cnt);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; sel = '0; op_data = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; sel2 = '0; op_data2 = '0;
    test_reset();
    test_basic();
    test_illegal_clear();
    test_stall();
    test_back_to_back();
    test_saturate();
    test_reset_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
